// File: rtl/mem_fifo_loader_if.sv
// Avalon-MM read-master and FIFO-write bundle of the matrix-vector fill engine.
interface mem_fifo_loader_if #(
  parameter int NUM_ROWS = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64
);
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read;
  logic                avm_waitrequest;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;
  logic [NUM_ROWS:0]   fifo_full;
  logic [NUM_ROWS:0]   fifo_sel;
  logic [7:0]          fifo_wdata;

  modport master (
    output avm_address, avm_read, fifo_sel, fifo_wdata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid, fifo_full
  );

  modport slave (
    input  avm_address, avm_read, fifo_sel, fifo_wdata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid, fifo_full
  );
endinterface

// File: rtl/mem_fifo_loader.sv
// Fill engine: reads NUM_ROWS+1 words over Avalon-MM, writes their bytes MSB-first, one per cycle, to the
// one-hot selected FIFO, stalling on that FIFO's full. Read timeout / ERR state only with `LOADER_TIMEOUT_EN.
module mem_fifo_loader #(
  parameter int                NUM_ROWS  = 8,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_i,
  input  logic              clr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  mem_fifo_loader_if.master bus
);
  localparam int NSEL   = NUM_ROWS + 1;
  localparam int BPW    = DATA_W / 8;
  localparam int WIDX_W = $clog2(NSEL);
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  if ((DATA_W % 8) != 0 || DATA_W < 8 || NUM_ROWS < 1 || TIMEOUT < 1) begin : g_param_check
    $error("mem_fifo_loader: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_UNPACK, S_DONE, S_FLUSH
`ifdef LOADER_TIMEOUT_EN
    , S_ERR
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NSEL-1:0]     fifo_sel_c;
  logic                avm_read_c;

  logic [BPW-1:0][7:0] word_bytes;
  logic [BIDX_W-1:0]   byte_pos;
  logic                tgt_full;

  assign word_bytes = word_q;
  assign byte_pos   = BIDX_W'(BPW - 1) - byte_idx_q;
  assign tgt_full   = bus.fifo_full[word_idx_q];

`ifdef LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             tmo_hit;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    fifo_sel_c = '0;
    avm_read_c = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    err_d = err_q;
    // Counts consecutive WAIT/FLUSH cycles without returning data.
    if (state_q == S_WAIT || state_q == S_FLUSH)
      tmo_d = bus.avm_readdatavalid ? '0 : tmo_q + TMO_W'(1);
    else
      tmo_d = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (fill_i && !clr_i) begin
          state_d    = S_REQ;
          word_idx_d = '0;
          addr_d     = BASE_ADDR;
        end
      end
      S_REQ: begin
        avm_read_c = 1'b1;
        if (clr_i)                     state_d = S_IDLE;
        else if (!bus.avm_waitrequest) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.avm_readdatavalid) begin
          // Data arriving together with the abort leaves nothing outstanding to flush.
          if (clr_i) state_d = S_IDLE;
          else begin
            state_d    = S_UNPACK;
            word_d     = bus.avm_readdata;
            byte_idx_d = '0;
          end
        end else if (clr_i) begin
          state_d = S_FLUSH;
        end
`ifdef LOADER_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
`endif
      end
      S_UNPACK: begin
        if (!tgt_full) fifo_sel_c = NSEL'(1) << word_idx_q;
        if (clr_i) begin
          state_d = S_IDLE;
        end else if (!tgt_full) begin
          if (byte_idx_q == BIDX_W'(BPW - 1)) begin
            if (word_idx_q == WIDX_W'(NUM_ROWS)) begin
              state_d = S_DONE;
            end else begin
              state_d    = S_REQ;
              word_idx_d = word_idx_q + WIDX_W'(1);
              addr_d     = BASE_ADDR + ADDR_W'(word_idx_q) + ADDR_W'(1);
            end
          end else begin
            byte_idx_d = byte_idx_q + BIDX_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FLUSH: begin
        if (bus.avm_readdatavalid) state_d = S_IDLE;
`ifdef LOADER_TIMEOUT_EN
        else if (tmo_hit)          state_d = S_IDLE;
`endif
      end
`ifdef LOADER_TIMEOUT_EN
      S_ERR: begin
        if (clr_i) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end else if (fill_i) begin
          state_d    = S_REQ;
          word_idx_d = '0;
          addr_d     = BASE_ADDR;
          err_d      = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
`ifdef LOADER_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.avm_address = addr_q;
  assign bus.avm_read    = avm_read_c;
  assign bus.fifo_sel    = fifo_sel_c;
  assign bus.fifo_wdata  = word_bytes[byte_pos];
  assign busy_o = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_UNPACK) ||
                  (state_q == S_DONE) || (state_q == S_FLUSH);
  assign done_o = (state_q == S_DONE);
`ifdef LOADER_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_mem_fifo_loader.sv
// Bench for mem_fifo_loader: Avalon slave model, per-byte write scoreboard and read-address scoreboard.
module tb_mem_fifo_loader;
  localparam int          NUM_ROWS = 8;
  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 64;
  localparam int          NSEL     = NUM_ROWS + 1;
  localparam logic [31:0] BASE     = 32'h40;

  logic clk, rst_n, fill, clr, busy, done, err;

  mem_fifo_loader_if #(.NUM_ROWS(NUM_ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_fifo_loader #(
    .NUM_ROWS(NUM_ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fill_i(fill), .clr_i(clr),
    .busy_o(busy), .done_o(done), .err_o(err), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int ws;
    int lat;
    bit bp;
    bit spam;
    int exp_done;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int ws_cfg = 0;
  int lat_cfg = 1;
  bit bp_cfg = 1'b0;
  bit withhold = 1'b0;
  int wr_total = 0;
  int acc_cnt = 0;
  int          exp_sel_q[$];
  logic [7:0]  exp_dat_q[$];
  logic [31:0] exp_addr_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] word_data(input int w);
    logic [63:0] d;
    for (int b = 0; b < 8; b++) d[63-8*b -: 8] = 8'(w * 8 + b);
    return d;
  endfunction

  // Slave + FIFO-full model drive inputs right after negedge; outputs are sampled 1 time unit later.
  initial begin : mon
    int cd;
    int stall;
    int rd_word;
    int bp_left;
    bit bp_arm;
    int es;
    logic [7:0]  ed;
    logic [31:0] hold_addr;
    logic [NSEL-1:0] full_bit;
    cd = 0; stall = 0; rd_word = 0; bp_left = 0; bp_arm = 1'b0; hold_addr = '0;
    full_bit = NSEL'(1) << 2;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata = '0;
    bus.fifo_full = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cd = 0; stall = 0; bp_left = 0; bp_arm = 1'b0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.fifo_full = '0;
        exp_sel_q.delete(); exp_dat_q.delete(); exp_addr_q.delete();
        continue;
      end
      bus.avm_readdatavalid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata = word_data(rd_word);
        end
      end
      bus.avm_waitrequest = 1'b0;
      if (stall > 0) chk("read_held", bus.avm_read, 1);
      if (bus.avm_read) begin
        if (stall == 0) hold_addr = bus.avm_address;
        else chk("addr_stable", bus.avm_address, hold_addr);
        if (stall < ws_cfg) begin
          bus.avm_waitrequest = 1'b1;
          stall++;
        end else begin
          stall = 0;
          acc_cnt++;
          rd_word = int'(bus.avm_address - BASE);
          if (exp_addr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_read actual=%0h required=none", bus.avm_address);
          end else begin
            chk("read_addr", bus.avm_address, exp_addr_q.pop_front());
          end
          if (!withhold) cd = lat_cfg;
        end
      end
      if (bp_arm) begin bp_left = 5; bp_arm = 1'b0; end
      if (bp_left > 0) begin bus.fifo_full = full_bit; bp_left--; end
      else bus.fifo_full = '0;
      #1;
      if (bus.fifo_sel != '0) begin
        wr_total++;
        chk("sel_onehot", $onehot(bus.fifo_sel), 1);
        chk("sel_vs_full", bus.fifo_sel & bus.fifo_full, 0);
        if (exp_sel_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual=sel %0h data %0h required=no write", bus.fifo_sel, bus.fifo_wdata);
        end else begin
          es = exp_sel_q.pop_front();
          ed = exp_dat_q.pop_front();
          chk("wr_sel", bus.fifo_sel, NSEL'(1) << es);
          chk("wr_dat", bus.fifo_wdata, ed);
        end
        if (bp_cfg && bus.fifo_sel[2] && bus.fifo_wdata == 8'd19) bp_arm = 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push_load();
    for (int w = 0; w < NSEL; w++) begin
      exp_addr_q.push_back(BASE + 32'(w));
      for (int b = 0; b < 8; b++) begin
        exp_sel_q.push_back(w);
        exp_dat_q.push_back(8'(w * 8 + b));
      end
    end
  endtask

  // fill is sampled at edge 0; the loop counter names the cycle after edge n-1 as cycle n.
  task automatic run_load(input vec_t v);
    int cyc;
    int wr0;
    bit seen;
    ws_cfg = v.ws; lat_cfg = v.lat; bp_cfg = v.bp;
    push_load();
    wr0 = wr_total;
    fill = 1'b1;
    step();
    fill = 1'b0;
    cyc = 1;
    seen = 1'b0;
    chk("busy_start", busy, 1);
    while (cyc < 400) begin
      if (done) begin seen = 1'b1; break; end
      if (v.spam) fill = (cyc % 17 == 0);
      step();
      cyc++;
    end
    fill = 1'b0;
    chk("done_seen", seen, 1);
    chk("done_cycle", cyc, v.exp_done);
    step();
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    chk("write_count", wr_total - wr0, 72);
    chk("sb_empty", exp_sel_q.size(), 0);
    chk("addr_sb_empty", exp_addr_q.size(), 0);
    chk("err_low", err, 0);
    step();
  endtask

  initial begin : main
    vec_t vecs[4];
    int a0;
    int w0;
    int n;
    vecs[0] = '{ws: 0, lat: 1, bp: 1'b0, spam: 1'b0, exp_done: 91};
    vecs[1] = '{ws: 3, lat: 4, bp: 1'b0, spam: 1'b0, exp_done: 145};
    vecs[2] = '{ws: 0, lat: 1, bp: 1'b1, spam: 1'b0, exp_done: 96};
    vecs[3] = '{ws: 0, lat: 1, bp: 1'b0, spam: 1'b1, exp_done: 91};

    rst_n = 1'b0; fill = 1'b0; clr = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_read", bus.avm_read, 0);
    chk("rst_sel", bus.fifo_sel, 0);
    chk("rst_addr", bus.avm_address, 0);
    chk("rst_wdata", bus.fifo_wdata, 0);
    rst_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 4; i++) run_load(vecs[i]);

    // Abort while the read is outstanding: data must be dropped.
    ws_cfg = 0; lat_cfg = 4; bp_cfg = 1'b0;
    exp_addr_q.push_back(BASE);
    a0 = acc_cnt;
    w0 = wr_total;
    fill = 1'b1;
    step();
    fill = 1'b0;
    n = 0;
    while (n < 20 && acc_cnt == a0) begin step(); n++; end
    chk("clr_accepted", acc_cnt - a0, 1);
    step();
    chk("wait_read_low", bus.avm_read, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("flush_busy", busy, 1);
    n = 0;
    while (n < 20 && busy) begin step(); n++; end
    chk("flush_len", n, 3);
    chk("flush_no_write", wr_total - w0, 0);
    repeat (3) step();
    run_load(vecs[0]);

    // Reset mid-UNPACK.
    ws_cfg = 0; lat_cfg = 1;
    push_load();
    w0 = wr_total;
    fill = 1'b1;
    step();
    fill = 1'b0;
    n = 0;
    while (n < 200 && (wr_total - w0) < 20) begin step(); n++; end
    chk("rst_mid_reached", wr_total - w0, 20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_read", bus.avm_read, 0);
    chk("mid_rst_sel", bus.fifo_sel, 0);
    chk("mid_rst_addr", bus.avm_address, 0);
    chk("mid_rst_wdata", bus.fifo_wdata, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    run_load(vecs[0]);

`ifdef LOADER_TIMEOUT_EN
    withhold = 1'b1;
    ws_cfg = 0; lat_cfg = 1;
    exp_addr_q.push_back(BASE);
    a0 = acc_cnt;
    fill = 1'b1;
    step();
    fill = 1'b0;
    n = 0;
    while (n < 20 && acc_cnt == a0) begin step(); n++; end
    chk("tmo_accepted", acc_cnt - a0, 1);
    n = 0;
    while (n < 40 && !err) begin step(); n++; end
    chk("tmo_cycles", n, 17);
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    step();
    chk("tmo_err_sticky", err, 1);
    withhold = 1'b0;
    run_load(vecs[0]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
